// File: rtl/alu_bist_if.sv
// Bus between the BIST controller and its external vector memory and ALU under test.
// The master side is the BIST; the slave side is the memory + ALU.
interface alu_bist_if #(
    parameter int N      = 64,
    parameter int ADDR_W = 5
);
    localparam int VEC_W = 3*N+5;

    logic [ADDR_W-1:0] vec_addr;
    logic [VEC_W-1:0]  vec_data;
    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic [3:0]        alu_control;
    logic [N-1:0]      alu_result;
    logic              alu_zero;

    modport master (
        output vec_addr, alu_a, alu_b, alu_control,
        input  vec_data, alu_result, alu_zero
    );

    modport slave (
        input  vec_addr, alu_a, alu_b, alu_control,
        output vec_data, alu_result, alu_zero
    );
endinterface

// File: rtl/alu_bist.sv
// ALU self-test controller: walks {op, a, b, exp_result, exp_zero} records,
// drives the ALU, compares its outputs and reports mismatch statistics.
module alu_bist #(
    parameter int N      = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vectors,
    alu_bist_if.master        bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   error_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx
);
    localparam int VEC_W = 3*N+5;
    localparam logic [ADDR_W:0] MAX_NV = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   nv_q, nv_d;
    logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
    logic [N-1:0]      alu_a_q, alu_a_d;
    logic [N-1:0]      alu_b_q, alu_b_d;
    logic [3:0]        alu_control_q, alu_control_d;
    logic [N-1:0]      exp_result_q, exp_result_d;
    logic              exp_zero_q, exp_zero_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   error_count_q, error_count_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] first_fail_idx_q, first_fail_idx_d;

    logic [3:0]      v_op;
    logic [N-1:0]    v_a, v_b, v_res;
    logic            v_zero;
    logic [ADDR_W:0] nv_clamped;
    logic            mismatch, last_vec, can_start;

    assign v_op   = bus.vec_data[VEC_W-1 -: 4];
    assign v_a    = bus.vec_data[3*N -: N];
    assign v_b    = bus.vec_data[2*N -: N];
    assign v_res  = bus.vec_data[N -: N];
    assign v_zero = bus.vec_data[0];

    assign nv_clamped = (num_vectors > MAX_NV) ? MAX_NV : num_vectors;
    assign can_start  = start && (state_q == IDLE || state_q == DONE);
    // 4-state compare so an X/Z from the ALU counts as a failure in simulation.
    assign mismatch   = (bus.alu_result !== exp_result_q) || (bus.alu_zero !== exp_zero_q);
    assign last_vec   = ({1'b0, idx_q} == (nv_q - (ADDR_W+1)'(1)));

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        nv_d             = nv_q;
        vec_addr_d       = vec_addr_q;
        alu_a_d          = alu_a_q;
        alu_b_d          = alu_b_q;
        alu_control_d    = alu_control_q;
        exp_result_d     = exp_result_q;
        exp_zero_d       = exp_zero_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        error_count_d    = error_count_q;
        fail_valid_d     = fail_valid_q;
        first_fail_idx_d = first_fail_idx_q;

        if (can_start) begin
            nv_d             = nv_clamped;
            idx_d            = '0;
            error_count_d    = '0;
            fail_valid_d     = 1'b0;
            first_fail_idx_d = '0;
            done_d           = 1'b0;
            pass_d           = 1'b0;
            // An empty run still spends one cycle in DONE before done rises.
            if (nv_clamped == '0) begin
                state_d = DONE;
                busy_d  = 1'b0;
            end else begin
                state_d = FETCH;
                busy_d  = 1'b1;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    vec_addr_d = idx_q;
                    state_d    = LOAD;
                end
                LOAD: begin
                    alu_control_d = v_op;
                    alu_a_d       = v_a;
                    alu_b_d       = v_b;
                    exp_result_d  = v_res;
                    exp_zero_d    = v_zero;
                    state_d       = CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (error_count_q != '1)
                            error_count_d = error_count_q + (ADDR_W+1)'(1);
                        if (!fail_valid_q) begin
                            fail_valid_d     = 1'b1;
                            first_fail_idx_d = idx_q;
                        end
                    end
                    if (last_vec) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (error_count_d == '0);
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
                DONE: begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (error_count_q == '0);
                end
                default: busy_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            nv_q             <= '0;
            vec_addr_q       <= '0;
            alu_a_q          <= '0;
            alu_b_q          <= '0;
            alu_control_q    <= '0;
            exp_result_q     <= '0;
            exp_zero_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            error_count_q    <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_idx_q <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            nv_q             <= nv_d;
            vec_addr_q       <= vec_addr_d;
            alu_a_q          <= alu_a_d;
            alu_b_q          <= alu_b_d;
            alu_control_q    <= alu_control_d;
            exp_result_q     <= exp_result_d;
            exp_zero_q       <= exp_zero_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            error_count_q    <= error_count_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_idx_q <= first_fail_idx_d;
        end
    end

    assign bus.vec_addr    = vec_addr_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_control = alu_control_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign error_count     = error_count_q;
    assign fail_valid      = fail_valid_q;
    assign first_fail_idx  = first_fail_idx_q;
endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test controller: the stimulus/checking side of the ALU interface, implemented in hardware.
- Walks a synchronous-read vector memory of {ALUControl, a, b, expected result, expected zero} records.
- Drives each record onto the ALU operand/control inputs, samples the ALU result/zero, and counts mismatches.
- Sits beside the datapath ALU for on-chip/FPGA self-test; the ALU under test is connected externally.

Parameters:
- N, 64, operand/result width.
- ADDR_W, 5, vector memory address width (up to 32 vectors).
- VEC_W, 3*N+5, vector record width; derived, not overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- num_vectors  in  ADDR_W+1  vectors to run; sampled when start is accepted.
- vec_addr  out  ADDR_W  vector memory address; registered.
- vec_data  in  VEC_W  vector memory data, valid the cycle after vec_addr changes.
- alu_a  out  N  ALU operand a; registered.
- alu_b  out  N  ALU operand b; registered.
- alu_control  out  4  ALU opcode; registered.
- alu_result  in  N  ALU result; combinational from alu_a/alu_b/alu_control.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  run in progress.
- done  out  1  run finished; level, held until the next start or reset.
- pass  out  1  valid when done=1; 1 iff error_count==0.
- error_count  out  ADDR_W+1  mismatching vectors in this run; saturating.
- fail_valid  out  1  at least one mismatch seen.
- first_fail_idx  out  ADDR_W  index of the first mismatching vector.

Behaviour:
- Record layout, MSB to LSB: op[3:0], a[N-1:0], b[N-1:0], exp_result[N-1:0], exp_zero. For N=64 the record is 197 bits.
- Reset values: every output 0, state IDLE, internal index 0.
- States and transitions:
  - IDLE: busy=0. If start=1, capture num_vectors, clear error_count/fail_valid/first_fail_idx, clear done/pass, set idx=0. Go to DONE if num_vectors==0, else FETCH.
  - FETCH: vec_addr<=idx; busy=1. Go to LOAD.
  - LOAD: latch op/a/b from vec_data into alu_control/alu_a/alu_b; latch exp_result/exp_zero internally. Go to CHECK.
  - CHECK: mismatch if alu_result!==exp_result or alu_zero!==exp_zero (full N-bit compare plus flag).
    - On mismatch: error_count++ unless already all-ones. If fail_valid==0, set fail_valid=1 and first_fail_idx=idx.
    - If idx==num_vectors-1, go to DONE; else idx++ and go to FETCH.
  - DONE: busy=0, done=1, pass=(error_count==0). alu_* outputs hold their last values. If start=1, restart exactly as from IDLE.
- Timing: exactly 3 cycles per vector. With start accepted at edge k, done=1 after edge k+3*num_vectors (after edge k+1 when num_vectors==0).
- num_vectors above 2^ADDR_W is clamped to 2^ADDR_W.
- start while busy=1 is ignored and has no effect on counters.
- reset asserted mid-run aborts immediately. All outputs return to 0, and nothing is retained from the partial run.
- The ALU is treated as purely combinational with settling within one cycle (LOAD→CHECK).
- Mismatch compare uses 4-state inequality in simulation; in synthesis this reduces to !=.

Test Plan:
- Clean run: load 5 vectors, including AND 1206&4404=52 zero=0, ADD 4781+1346=6127, SUB 2108-2669=-561, and AND 0&0=0 zero=1; connect a correct ALU. Start → done after 15 cycles, pass=1, error_count=0, fail_valid=0.
- Injected fault: vector 2 with exp_zero flipped (OR -1592|-1624=-1560, exp_zero=1); correct ALU → error_count=1, fail_valid=1, first_fail_idx=2, pass=0.
- Two faults at indices 1 and 3 → error_count=2, first_fail_idx=1.
- Overflow vector: ADD 0x7FFF_FFFF_FFFF_FFFF + 1, expected 0x8000_0000_0000_0000, zero=0; correct ALU → pass=1.
- num_vectors=0 → done=1 one cycle after start, pass=1, vec_addr stays 0. Then num_vectors=32 → all 32 addresses visited in order, done after 96 cycles.
- Robustness:
  - Pulse start at cycle 5 of a run → no effect.
  - Assert reset at cycle 7 → all outputs 0 next edge.
  - Restart from DONE after a failing run → counters cleared, fresh result reported.
